// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

    // Quotient returned on divide-by-zero; slice down to the operand width.
    localparam logic [63:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate: y = neg ? -a : a.
module div_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned, flushable).
// Define ITER_DIVIDER_EARLY_OUT_EN to skip iteration for zero divisor or |dividend| < |divisor|.
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             stallreq_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    div_state_t       state, state_next;
    logic [WIDTH-1:0] rem, quo, dsor;
    logic             sign_q, sign_r;
    logic [CNT_W-1:0] cnt;

    logic             neg_dend, neg_dsor, accept, skip_calc;
    logic [WIDTH-1:0] abs_dend, abs_dsor, fix_q, fix_r;
    logic [WIDTH:0]   rem_sh, trial;

    assign neg_dend = signed_i & dividend_i[WIDTH-1];
    assign neg_dsor = signed_i & divisor_i[WIDTH-1];
    assign accept   = (state == IDLE) & start_i & ~flush_i;

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dend (.a(dividend_i), .neg(neg_dend), .y(abs_dend));
    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dsor (.a(divisor_i),  .neg(neg_dsor), .y(abs_dsor));
    div_abs_neg #(.WIDTH(WIDTH)) u_fix_q    (.a(quo),        .neg(sign_q),   .y(fix_q));
    div_abs_neg #(.WIDTH(WIDTH)) u_fix_r    (.a(rem),        .neg(sign_r),   .y(fix_r));

`ifdef ITER_DIVIDER_EARLY_OUT_EN
    assign skip_calc = (abs_dsor == '0) | (abs_dend < abs_dsor);
`else
    assign skip_calc = 1'b0;
`endif

    // One restoring step: shift {rem,quo} left, trial-subtract on WIDTH+1 bits.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dsor};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = skip_calc ? FIX : CALC;
            CALC: begin
                if (flush_i)                         state_next = IDLE;
                else if (cnt == CNT_W'(1))           state_next = FIX;
            end
            FIX:  state_next = flush_i ? IDLE : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy_o     = (state == CALC) | (state == FIX);
    assign stallreq_o = busy_o | ((state == IDLE) & start_i);
    assign valid_o    = (state == DONE) & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem         <= '0;
            quo         <= '0;
            dsor        <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            cnt         <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    dsor   <= abs_dsor;
                    sign_q <= neg_dend ^ neg_dsor;
                    sign_r <= neg_dend;
                    cnt    <= CNT_W'(WIDTH);
                    // Early-out parks the dividend magnitude as the remainder.
                    if (skip_calc) begin
                        rem <= abs_dend;
                        quo <= '0;
                    end else begin
                        rem <= '0;
                        quo <= abs_dend;
                    end
                end
                CALC: if (!flush_i) begin
                    rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt - CNT_W'(1);
                end
                // Zero divisor: the remainder path already restores the original dividend.
                FIX: if (!flush_i) begin
                    quotient_o  <= (dsor == '0) ? DIV_BY_ZERO_Q[WIDTH-1:0] : fix_q;
                    remainder_o <= fix_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: random + directed ops against an arithmetic model.
module tb_iter_divider;

    localparam int W = 32;

    logic          clk, rst, flush_i, start_i, signed_i;
    logic [W-1:0]  dividend_i, divisor_i;
    logic          stallreq_o, busy_o, valid_o;
    logic [W-1:0]  quotient_o, remainder_o;

    iter_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .start_i(start_i),
        .signed_i(signed_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
        .stallreq_o(stallreq_o), .busy_o(busy_o), .valid_o(valid_o),
        .quotient_o(quotient_o), .remainder_o(remainder_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0, n_bad = 0;
    logic [W-1:0] prev_q = '0, prev_r = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [W-1:0] mag(input bit s, input logic [W-1:0] v);
        longint x;
        x = s ? longint'($signed(v)) : longint'(v);
        if (x < 0) x = -x;
        return x[W-1:0];
    endfunction

    task automatic ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sd, qq, rr;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
            qq = sa / sd;
            rr = sa % sd;
            q  = qq[W-1:0];
            r  = rr[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'(valid_o), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("quotient", 64'(quotient_o), 64'(e.q));
                chk("remainder", 64'(remainder_o), 64'(e.r));
                chk("latency", 64'(cyc), 64'(e.due));
                chk("stall_in_done", 64'(stallreq_o), 64'(0));
            end
        end
    end

    task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   lat;
        lat = W + 2;
`ifdef ITER_DIVIDER_EARLY_OUT_EN
        if (b == 0 || mag(s, a) < mag(s, b)) lat = 2;
`endif
        ref_div(s, a, b, e.q, e.r);
        e.due  = cyc + lat;
        prev_q = e.q;
        prev_r = e.r;
        sb.push_back(e);
        start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b;
        #1 chk("stall_on_start", 64'(stallreq_o), 64'(1));
        @(negedge clk);
        start_i = 1'b0;
        #1 chk("busy_after_start", 64'(busy_o), 64'(1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(s, a, b);
        wait_idle();
    endtask

    initial begin
        logic [W-1:0] a, b;
        int           c0, mode;
        rst = 1'b1; flush_i = 1'b0; start_i = 1'b0; signed_i = 1'b0;
        dividend_i = '0; divisor_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_quotient", 64'(quotient_o), 64'(0));
        chk("rst_remainder", 64'(remainder_o), 64'(0));
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        run(1'b0, 32'd100, 32'd7);
        run(1'b1, 32'hFFFF_FFF9, 32'd2);
        run(1'b0, 32'hFFFF_FFF9, 32'd2);
        run(1'b0, 32'd5, 32'd0);
        run(1'b1, 32'hFFFF_FFFB, 32'd0);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run(1'b0, 32'd3, 32'd10);
        run(1'b1, 32'hFFFF_FFFD, 32'd10);

        // Flush mid-CALC: no result, outputs keep the previous op's values.
        c0 = cyc;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        while (cyc < c0 + 10) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush_busy", 64'(busy_o), 64'(0));
        chk("flush_hold_q", 64'(quotient_o), 64'(prev_q));
        chk("flush_hold_r", 64'(remainder_o), 64'(prev_r));
        @(negedge clk);
        run(1'b0, 32'd9, 32'd3);

        // Flush together with start in IDLE drops the request.
        start_i = 1'b1; flush_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        #1 chk("flush_start_ignored", 64'(busy_o), 64'(0));
        repeat (3) @(negedge clk);

        // Synchronous reset mid-CALC clears everything.
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy_o), 64'(0));
        chk("midrst_valid", 64'(valid_o), 64'(0));
        chk("midrst_q", 64'(quotient_o), 64'(0));
        chk("midrst_r", 64'(remainder_o), 64'(0));
        @(negedge clk);

        // start_i held through DONE: exactly one result for the single accepted start.
        issue(1'b0, 32'd1000, 32'd13);
        start_i = 1'b1;
        repeat (W) @(negedge clk);
        start_i = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            case (mode)
                0: b = '0;
                1, 2, 3: b = $urandom_range(1, 255);
                4: begin a = $urandom_range(0, 20); b = $urandom_range(1, 40); end
                5: b = '1;
                default: ;
            endcase
            run(1'($urandom_range(0, 1)), a, b);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle radix-2 restoring divider. It replaces the single-cycle combinational div/mod path in the execute stage.
- Operands are accepted from EX on a start pulse. EX is stalled while the unit iterates. Quotient and remainder are returned together with a one-cycle valid.
- Supports signed and unsigned operation and a pipeline flush. It is parametrised in operand width.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  abort the current operation (exception or branch flush).
- start_i  in  1  request a divide. Sampled only in IDLE.
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned.
- dividend_i  in  WIDTH  dividend.
- divisor_i  in  WIDTH  divisor.
- stallreq_o  out  1  EX stall request.
- busy_o  out  1  unit is in CALC or FIX.
- valid_o  out  1  results valid this cycle (one-cycle pulse).
- quotient_o  out  WIDTH  quotient.
- remainder_o  out  WIDTH  remainder.

Behaviour:
- Reset: state=IDLE; busy_o=0; valid_o=0; quotient_o=0; remainder_o=0; counter=0. rst has priority over flush_i and start_i.
- Operand capture in IDLE when start_i=1:
  - Register the magnitudes |dividend| and |divisor|. Take the absolute value only if signed_i=1.
  - Register sign_q = dend[MSB]^dsor[MSB] and sign_r = dend[MSB]. Both are 0 when signed_i=0.
  - Clear the partial remainder. Set counter=WIDTH. Go to CALC.
- CALC, one step per cycle:
  - Shift {rem,quo} left by 1 and form trial = rem - dsor on WIDTH+1 bits.
  - If trial is non-negative: rem = trial and quo LSB = 1. Otherwise quo LSB = 0.
  - Decrement counter. When counter reaches 1 and the step completes, go to FIX.
- FIX:
  - Negate quo if sign_q; negate rem if sign_r.
  - Divisor zero: force quo = all-ones and rem = original dividend, regardless of signed_i.
  - Load quotient_o and remainder_o. Go to DONE.
- DONE: valid_o=1 for exactly one cycle, then IDLE. start_i in DONE is ignored.
- Outputs hold their last values in IDLE. They change only on the FIX→DONE load.
- Latency: start_i sampled at edge N → valid_o high in the cycle after edge N+WIDTH+1, i.e. WIDTH+2 cycles.
- stallreq_o = (state==CALC) | (state==FIX) | (state==IDLE & start_i). It is combinational and drops in DONE so EX captures the result.
- busy_o = (state==CALC) | (state==FIX).
- Signed overflow (MIN / -1): quo = MIN, rem = 0. This falls out naturally; no special case.
- flush_i in CALC, FIX or DONE: go to IDLE next edge. valid_o is suppressed that cycle and outputs are not updated. flush_i together with start_i in IDLE: the request is ignored.
- A new start_i is accepted the cycle after returning to IDLE.

Optional Feature:
- Macro: ITER_DIVIDER_EARLY_OUT_EN.
- Defined: at capture, if divisor==0 or |dividend| < |divisor| (unsigned magnitude compare), skip CALC and go directly to FIX.
  - For the small-dividend case: quo = 0, rem = dividend magnitude.
  - Latency becomes 2 cycles. All other cases are unchanged.
- Undefined: fixed WIDTH+2 latency for all operands. No compare logic is generated.

Decomposition:
- Shared package div_pkg:
  - state typedef div_state_t {IDLE, CALC, FIX, DONE}.
  - DIV_BY_ZERO_Q constant (all-ones).
- Sub-module div_abs_neg: conditional two's-complement negate, WIDTH-parametrised. Used for capture (abs) and for FIX (sign restore).
- The step logic stays inline in iter_divider.

Test Plan:
- Unsigned 100/7, WIDTH=32 → valid_o at cycle 34 after start; quotient=14, remainder=2; stallreq_o high cycles 0–33.
- Signed -7/2 (0xFFFFFFF9 / 2) → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Same operands with signed_i=0 → quotient=0x7FFFFFFC, remainder=1.
- Divide by zero, 5/0 → quotient=0xFFFFFFFF, remainder=5. Signed MIN/-1 (0x80000000 / 0xFFFFFFFF) → quotient=0x80000000, remainder=0.
- Flush: start 100/7, flush_i at cycle 10 → no valid_o; busy_o=0 at cycle 11; outputs keep old values. Restart 9/3 at cycle 12 → quotient=3, remainder=0 at cycle 46.
- rst asserted mid-CALC → all outputs 0 next cycle, state IDLE. start_i held high through DONE → exactly one valid_o per accepted start.
- With ITER_DIVIDER_EARLY_OUT_EN: 3/10 → valid_o at cycle 2, quotient=0, remainder=3; 100/7 still takes 34 cycles.
